// File: rtl/jk_bank_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_pkg (package)
// Purpose : Shared command encodings and FSM state type for the JK bank
//           sequencer and its testbench.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
package jk_pkg;

  // Command op encodings carried on cmd_op
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_CLEAR   = 3'd1;
  localparam logic [2:0] OP_PRESET  = 3'd2;
  localparam logic [2:0] OP_TOGGLE  = 3'd3;
  localparam logic [2:0] OP_LOAD    = 3'd4;
  localparam logic [2:0] OP_CNT_UP  = 3'd5;
  localparam logic [2:0] OP_CNT_DN  = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_bank_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank_sequencer_if
// Purpose : Command handshake bundle between a host and the sequencer.
// Ports   : cmd_valid/cmd_op/cmd_data/cmd_len driven by the host (master),
//           cmd_ready driven by the sequencer (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_data,
                  output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data,
                  input cmd_len, output cmd_ready);
endinterface : jk_bank_sequencer_if
`default_nettype wire

// File: rtl/jk_bank_sequencer_bank.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank
// Purpose : WIDTH independent JK flip-flops with asynchronous active-low
//           clear. Cell rule: 00 hold, 01 reset, 10 set, 11 toggle.
// Ports   : clk, rst (async, 0 = reset), j/k (per-cell inputs),
//           q (state), qn (complement).
// Revision: 1.0 - initial release
// ============================================================================
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] j,
  input  wire logic [WIDTH-1:0] k,
  output logic      [WIDTH-1:0] q,
  output logic      [WIDTH-1:0] qn
);
  import jk_pkg::*;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic cell_q;
    logic cell_d;

    always_comb begin
      cell_d = cell_q;
      case ({j[gi], k[gi]})
        2'b01:   cell_d = 1'b0;
        2'b10:   cell_d = 1'b1;
        2'b11:   cell_d = ~cell_q;
        default: cell_d = cell_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cell_q <= 1'b0;
      else      cell_q <= cell_d;
    end

    assign q[gi] = cell_q;
  end

  assign qn = ~q;

endmodule : jk_bank
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank_sequencer
// Purpose : Command-driven controller that owns the J/K inputs of a JK bank
//           and sequences clear/preset/toggle/load and multi-step counts.
// Ports   : clk, rst (async, 0 = reset), cmd (handshake, slave side),
//           abort (ends a running count), j/k (bank drive), q/qn (bank
//           state), busy (not idle), done/err (completion pulses).
// Revision: 1.0 - initial release
// ============================================================================
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  jk_bank_sequencer_if.slave    cmd,
  input  wire logic             abort,
  output logic      [WIDTH-1:0] j,
  output logic      [WIDTH-1:0] k,
  output logic      [WIDTH-1:0] q,
  output logic      [WIDTH-1:0] qn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import jk_pkg::*;

  state_e           state_q, state_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [LEN_W-1:0] remain_q, remain_d;

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             up_carry;
  logic             dn_carry;

  // Next-state / command capture
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d     = cmd.cmd_op;
          data_d   = cmd.cmd_data;
          remain_d = cmd.cmd_len;
          if (cmd.cmd_op == OP_CNT_UP || cmd.cmd_op == OP_CNT_DN) begin
            if (cmd.cmd_len != '0) begin
              state_d = ST_COUNT;
            end else begin
              // Zero-length count degenerates to a NOP so APPLY drives nothing
              op_d    = OP_NOP;
              state_d = ST_APPLY;
            end
          end else begin
            state_d = ST_APPLY;
          end
        end
      end
      ST_APPLY: state_d = ST_DONE;
      ST_COUNT: begin
        // The step on this edge always applies; stay only if more remain
        if (remain_q > LEN_W'(1) && !abort) remain_d = remain_q - LEN_W'(1);
        else                                 state_d  = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      remain_q <= remain_d;
    end
  end

  // Counter toggle enables: a bit toggles when all lower bits are 1 (up)
  // or all lower bits are 0 (down).
  always_comb begin
    up_carry = 1'b1;
    dn_carry = 1'b1;
    up_t     = '0;
    dn_t     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i]  = up_carry;
      dn_t[i]  = dn_carry;
      up_carry = up_carry & q[i];
      dn_carry = dn_carry & ~q[i];
    end
  end

  // J/K decode, active only while applying or counting
  always_comb begin
    j = '0;
    k = '0;
    if (state_q == ST_APPLY || state_q == ST_COUNT) begin
      case (op_q)
        OP_CLEAR:  k = '1;
        OP_PRESET: j = '1;
        OP_TOGGLE: begin j = data_q; k = data_q;  end
        OP_LOAD:   begin j = data_q; k = ~data_q; end
        OP_CNT_UP: begin j = up_t;   k = up_t;    end
        OP_CNT_DN: begin j = dn_t;   k = dn_t;    end
        default:   begin j = '0;     k = '0;      end
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err           = (state_q == ST_DONE) && (op_q == OP_ILLEGAL);

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q),
    .qn  (qn)
  );

endmodule : jk_bank_sequencer
`default_nettype wire
